// File: rtl/stack_pointer_unit.sv
// Down-growing stack pointer with saturating push/pop, sticky overflow/underflow
// flags and a one-cycle settle indicator for the downstream address counter.
module stack_pointer_unit #(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] TOP  = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             clr_err,
    output logic [WIDTH-1:0] sp,
    output logic [WIDTH-1:0] mem_addr,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf,
    output logic             busy_n
);

    logic [WIDTH-1:0] sp_reg, sp_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             busy_n_reg, busy_n_next;

    logic push_only, pop_only;
    logic ovf_event, unf_event;

    assign push_only = push & ~pop & ~load;
    assign pop_only  = pop & ~push & ~load;

    assign full  = (sp_reg == '0);
    assign empty = (sp_reg == TOP);

    assign ovf_event = push_only & full;
    assign unf_event = pop_only & empty;

    always_comb begin
        sp_next  = sp_reg;
        ovf_next = (ovf_reg & ~clr_err) | ovf_event;
        unf_next = (unf_reg & ~clr_err) | unf_event;
        if (load) begin
            sp_next  = load_data;
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end else if (push_only && !full) begin
            sp_next = sp_reg - WIDTH'(1);
        end else if (pop_only && !empty) begin
            sp_next = sp_reg + WIDTH'(1);
        end
        // Only an actual value change needs settle time downstream.
        busy_n_next = (sp_next == sp_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg     <= TOP;
            ovf_reg    <= 1'b0;
            unf_reg    <= 1'b0;
            busy_n_reg <= 1'b1;
        end else begin
            sp_reg     <= sp_next;
            ovf_reg    <= ovf_next;
            unf_reg    <= unf_next;
            busy_n_reg <= busy_n_next;
        end
    end

    // A pop reads the slot just above the pointer; everything else uses sp itself.
    assign mem_addr = pop_only ? (sp_reg + WIDTH'(1)) : sp_reg;

    assign sp     = sp_reg;
    assign ovf    = ovf_reg;
    assign unf    = unf_reg;
    assign busy_n = busy_n_reg;

endmodule

// File: tb/tb_stack_pointer_unit.sv
// Directed bench for stack_pointer_unit with hand-computed expected values.
module tb_stack_pointer_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push, pop, load, clr_err;
    logic [7:0] load_data;
    logic [7:0] sp, mem_addr;
    logic       empty, full, ovf, unf, busy_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stack_pointer_unit #(.WIDTH(8), .TOP(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .load(load),
        .load_data(load_data), .clr_err(clr_err), .sp(sp), .mem_addr(mem_addr),
        .empty(empty), .full(full), .ovf(ovf), .unf(unf), .busy_n(busy_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end else begin
            $display("ok   %s: %0h", tag, observed);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 0; pop = 0; load = 0; clr_err = 0;
    endtask

    initial begin
        rst_n = 0; load_data = 8'h00;
        idle();
        tick(); tick();
        check_eq("rst_sp", sp, 8'hFF);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_unf", unf, 0);
        check_eq("rst_busy_n", busy_n, 1);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        rst_n = 1;
        tick();

        // Pop on empty stack
        pop = 1;
        #1 check_eq("pop_empty_addr", mem_addr, 8'h00);
        tick(); idle();
        check_eq("pop_empty_sp", sp, 8'hFF);
        check_eq("pop_empty_unf", unf, 1);
        check_eq("pop_empty_empty", empty, 1);
        check_eq("pop_empty_busy_n", busy_n, 1);
        clr_err = 1;
        tick(); idle();
        check_eq("clr_unf", unf, 0);

        // Three pushes
        push = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq($sformatf("push%0d_addr", i), mem_addr, 8'hFF - i);
            tick();
            check_eq($sformatf("push%0d_sp", i), sp, 8'hFE - i);
            check_eq($sformatf("push%0d_busy_n", i), busy_n, 0);
        end
        idle();
        tick();
        check_eq("hold_busy_n", busy_n, 1);

        // Pop from FC
        pop = 1;
        #1 check_eq("pop_fc_addr", mem_addr, 8'hFD);
        tick(); idle();
        check_eq("pop_fc_sp", sp, 8'hFD);
        check_eq("pop_fc_busy_n", busy_n, 0);

        // Load 0, push -> overflow
        load = 1; load_data = 8'h00;
        tick(); idle();
        check_eq("load0_sp", sp, 8'h00);
        check_eq("load0_full", full, 1);
        push = 1;
        tick(); idle();
        check_eq("ovf_sp", sp, 8'h00);
        check_eq("ovf_flag", ovf, 1);
        check_eq("ovf_busy_n", busy_n, 1);
        clr_err = 1;
        tick(); idle();
        check_eq("clr_ovf", ovf, 0);
        // clr_err with a new overflow in the same cycle keeps the flag
        push = 1; clr_err = 1;
        tick(); idle();
        check_eq("clr_vs_new_ovf", ovf, 1);

        // Load clears flags; push+pop together holds
        load = 1; load_data = 8'h80;
        tick(); idle();
        check_eq("load80_ovf", ovf, 0);
        push = 1; pop = 1;
        #1 check_eq("rmw_addr", mem_addr, 8'h80);
        tick(); idle();
        check_eq("rmw_sp", sp, 8'h80);
        check_eq("rmw_flags", {ovf, unf}, 2'b00);
        check_eq("rmw_busy_n", busy_n, 1);
        push = 1; pop = 1; load = 1; load_data = 8'h10;
        tick(); idle();
        check_eq("load_prio_sp", sp, 8'h10);
        load = 1; load_data = 8'h10;
        tick(); idle();
        check_eq("load_same_busy_n", busy_n, 1);

        // Build sp=20 with ovf set, then async reset mid-cycle
        load = 1; load_data = 8'h00;
        tick(); idle();
        push = 1;
        tick(); idle();
        pop = 1;
        for (int i = 0; i < 32; i++) tick();
        idle();
        check_eq("pre_rst_sp", sp, 8'h20);
        check_eq("pre_rst_ovf", ovf, 1);
        #2 rst_n = 0;
        #1;
        check_eq("async_rst_sp", sp, 8'hFF);
        check_eq("async_rst_ovf", ovf, 0);
        check_eq("async_rst_busy_n", busy_n, 1);
        // Request during reset is ignored; first request after release honoured
        push = 1;
        tick();
        check_eq("push_in_rst_sp", sp, 8'hFF);
        rst_n = 1;
        tick(); idle();
        check_eq("push_after_rst_sp", sp, 8'hFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
